// File: rtl/axi_read_arbiter_if.sv
// Signal bundle between the fetch/load requesters, the read arbiter and the
// AXI read-address/read-data channels. The master modport is the arbiter's
// view; the slave modport is the view of everything around it.
interface axi_read_arbiter_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    // requester 0 (instruction fetch)
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic                  req0_ready;
    logic                  resp0_valid;
    logic [DATA_WIDTH-1:0] resp0_data;
    logic                  resp0_last;
    logic                  resp0_err;
    // requester 1 (data load)
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  req1_ready;
    logic                  resp1_valid;
    logic [DATA_WIDTH-1:0] resp1_data;
    logic                  resp1_last;
    logic                  resp1_err;
    // AXI read address channel
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    // AXI read data channel
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  req0_valid, req0_addr, req1_valid, req1_addr,
        output req0_ready, resp0_valid, resp0_data, resp0_last, resp0_err,
        output req1_ready, resp1_valid, resp1_data, resp1_last, resp1_err,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output req0_valid, req0_addr, req1_valid, req1_addr,
        input  req0_ready, resp0_valid, resp0_data, resp0_last, resp0_err,
        input  req1_ready, resp1_valid, resp1_data, resp1_last, resp1_err,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel pair between the fetch
// (port 0) and load (port 1) line-fill requesters. One outstanding 8-beat
// 64-bit wrapping burst at a time; returned beats are registered and steered
// to the granted port, with a burst error reported alongside the last beat.
module axi_read_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input logic                clk,
    input logic                reset,
    axi_read_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic [1:0]            req_ready_q, req_ready_d;
    logic [1:0]            resp_valid_q, resp_valid_d;
    logic [1:0]            resp_last_q, resp_last_d;
    logic [1:0]            resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [2:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;

    logic                  pick;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic                  beat;
    logic                  beat_err;
    logic [ID_WIDTH-1:0]   grant_id;

    // Next-state, arbitration and beat steering.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_last_d  = '0;
        resp_err_d   = '0;
        resp_data_d  = resp_data_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;

        // Tie goes to the port not granted last; otherwise whoever asks.
        pick      = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
        pick_addr = pick ? bus.req1_addr : bus.req0_addr;
        grant_id  = ID_WIDTH'(grant_q);
        beat      = rready_q && bus.m_axi_rvalid;
        beat_err  = (bus.m_axi_rresp != 2'b00)
                  || (bus.m_axi_rlast && (beat_cnt_q != 3'd7))
                  || (bus.m_axi_rid != grant_id);

        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    araddr_d     = {pick_addr[ADDR_WIDTH-1:3], 3'b000};
                    arvalid_d    = 1'b1;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (bus.m_axi_arready) begin
                    arvalid_d            = 1'b0;
                    rready_d             = 1'b1;
                    req_ready_d[grant_q] = 1'b1;
                    beat_cnt_d           = '0;
                    err_d                = 1'b0;
                    state_d              = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    resp_valid_d[grant_q] = 1'b1;
                    resp_last_d[grant_q]  = bus.m_axi_rlast;
                    resp_err_d[grant_q]   = bus.m_axi_rlast && (err_q || beat_err);
                    resp_data_d           = bus.m_axi_rdata;
                    beat_cnt_d            = beat_cnt_q + 3'd1;
                    err_d                 = err_q || beat_err;
                    // A counter wrap alone never ends the burst; only rlast does.
                    if (bus.m_axi_rlast) begin
                        rready_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_last_q  <= '0;
            resp_err_q   <= '0;
            resp_data_q  <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

    assign bus.m_axi_arid    = ID_WIDTH'(grant_q);
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = 8'h07;
    assign bus.m_axi_arsize  = 3'h3;
    assign bus.m_axi_arburst = 2'b10;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'h0;
    assign bus.m_axi_arprot  = 3'h6;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;

    assign bus.req0_ready  = req_ready_q[0];
    assign bus.resp0_valid = resp_valid_q[0];
    assign bus.resp0_data  = resp_data_q;
    assign bus.resp0_last  = resp_last_q[0];
    assign bus.resp0_err   = resp_err_q[0];
    assign bus.req1_ready  = req_ready_q[1];
    assign bus.resp1_valid = resp_valid_q[1];
    assign bus.resp1_data  = resp_data_q;
    assign bus.resp1_last  = resp_last_q[1];
    assign bus.resp1_err   = resp_err_q[1];

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: plays both requesters and the AXI slave, and
// predicts grants, AR fields and returned beats from the arbitration and
// error rules (round-robin flag, beat index, sticky bad-beat flag).
module tb_axi_read_arbiter;
    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_read_arbiter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference state: which port won the last grant, and requester addresses.
    logic          model_last_grant;
    logic [AW-1:0] req_addr [2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [AW-1:0] a);
        req_addr[p] = a;
        if (p == 0) begin
            bus.req0_valid = v;
            bus.req0_addr  = a;
        end else begin
            bus.req1_valid = v;
            bus.req1_addr  = a;
        end
    endtask

    function automatic logic req_v(input int p);
        return (p == 0) ? bus.req0_valid : bus.req1_valid;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    // Every output whose reset value is zero, packed together.
    function automatic logic [214:0] zero_outputs();
        return {bus.m_axi_arvalid, bus.m_axi_rready, bus.req0_ready, bus.req1_ready,
                bus.resp0_valid, bus.resp1_valid, bus.resp0_last, bus.resp1_last,
                bus.resp0_err, bus.resp1_err, bus.m_axi_araddr, bus.m_axi_arid,
                bus.resp0_data, bus.resp1_data};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rid     = '0;
        bus.m_axi_rdata   = '0;
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        step();
        step();
        reset = 1'b0;
        model_last_grant = 1'b1;
    endtask

    // One complete transaction driven from the requester/slave side. Beat i
    // (1-based) may carry a bad rresp or a bad rid; rlast goes on beat nbeats.
    // abort_at > 0 asserts reset together with that beat.
    task automatic run_burst(input int nbeats, input int ar_delay, input int stall_mode,
                             input int bad_resp_beat, input int bad_rid_beat,
                             input int abort_at, input logic seq_data);
        logic          g;
        logic          ng;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] d;
        logic          bad_seen;
        logic          last;
        logic          exp_err;
        int            waited;
        int            stalls;

        g        = (req_v(0) && req_v(1)) ? ~model_last_grant : req_v(1);
        ng       = ~g;
        exp_addr = {req_addr[g][AW-1:3], 3'b000};

        waited = 0;
        do begin
            step();
            waited++;
        end while (!bus.m_axi_arvalid && waited < 20);
        vectors++;
        if (waited !== 1) begin
            miscompares++;
            $display("FAIL ar_latency: arvalid after %0d cycles, required 1", waited);
        end
        if (!bus.m_axi_arvalid) return;

        vectors++;
        if ({bus.m_axi_arid, bus.m_axi_araddr} !== {IDW'(g), exp_addr}) begin
            miscompares++;
            $display("FAIL ar_id_addr: arid=%0h araddr=%h, required arid=%0h araddr=%h",
                     bus.m_axi_arid, bus.m_axi_araddr, g, exp_addr);
        end
        vectors++;
        if ({bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock,
             bus.m_axi_arcache, bus.m_axi_arprot} !== {8'h07, 3'h3, 2'b10, 1'b0, 4'h0, 3'h6}) begin
            miscompares++;
            $display("FAIL ar_fields: len=%h size=%h burst=%h lock=%b cache=%h prot=%h, required 07 3 2 0 0 6",
                     bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock,
                     bus.m_axi_arcache, bus.m_axi_arprot);
        end

        for (int i = 0; i < ar_delay; i++) begin
            bus.m_axi_arready = 1'b0;
            step();
            vectors++;
            if ({bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arid} !== {1'b1, exp_addr, IDW'(g)}) begin
                miscompares++;
                $display("FAIL ar_hold: arvalid=%b araddr=%h arid=%0h, required 1 %h %0h",
                         bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arid, exp_addr, g);
            end
        end
        bus.m_axi_arready = 1'b1;
        step();
        bus.m_axi_arready = 1'b0;
        vectors++;
        if ({bus.req1_ready, bus.req0_ready, bus.m_axi_rready, bus.m_axi_arvalid} !== {g, ng, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL handshake: ready1=%b ready0=%b rready=%b arvalid=%b, required %b %b 1 0",
                     bus.req1_ready, bus.req0_ready, bus.m_axi_rready, bus.m_axi_arvalid, g, ng);
        end
        model_last_grant = g;
        set_req(int'(g), 1'b0, rand_addr());

        bad_seen = 1'b0;
        for (int i = 1; i <= nbeats; i++) begin
            stalls = (stall_mode == 1) ? ((i == 1) ? 0 : 2)
                   : (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s < stalls; s++) begin
                bus.m_axi_rvalid = 1'b0;
                step();
                vectors++;
                if ({bus.m_axi_rready, bus.resp1_valid, bus.resp0_valid} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL resp_stall: rready=%b valid1=%b valid0=%b, required 1 0 0",
                             bus.m_axi_rready, bus.resp1_valid, bus.resp0_valid);
                end
            end

            d    = seq_data ? DW'(i - 1) : {$urandom, $urandom};
            last = (i == nbeats);
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = d;
            bus.m_axi_rresp  = (i == bad_resp_beat) ? 2'b10 : 2'b00;
            bus.m_axi_rid    = (i == bad_rid_beat) ? IDW'(ng) : IDW'(g);
            bus.m_axi_rlast  = last;
            bad_seen = bad_seen || (i == bad_resp_beat) || (i == bad_rid_beat);

            if (i == abort_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                model_last_grant = 1'b1;
                vectors++;
                if (zero_outputs() !== '0) begin
                    miscompares++;
                    $display("FAIL abort_reset: outputs=%h, required all zero", zero_outputs());
                end
                // The slave keeps talking after reset; nothing may be forwarded.
                for (int s = 0; s < 3; s++) begin
                    bus.m_axi_rdata = {$urandom, $urandom};
                    bus.m_axi_rlast = (s == 2);
                    step();
                    vectors++;
                    if ({bus.m_axi_rready, bus.m_axi_arvalid, bus.resp1_valid, bus.resp0_valid} !== 4'b0000) begin
                        miscompares++;
                        $display("FAIL abort_quiet: rready=%b arvalid=%b valid1=%b valid0=%b, required 0 0 0 0",
                                 bus.m_axi_rready, bus.m_axi_arvalid, bus.resp1_valid, bus.resp0_valid);
                    end
                end
                bus.m_axi_rvalid = 1'b0;
                bus.m_axi_rlast  = 1'b0;
                return;
            end

            step();
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rlast  = 1'b0;
            bus.m_axi_rresp  = 2'b00;
            // Error at the last beat: any bad beat so far, or rlast not on a
            // multiple of eight beats.
            exp_err = last && (bad_seen || (i % 8 != 0));
            vectors++;
            if ({bus.resp1_valid, bus.resp0_valid, bus.resp1_last, bus.resp0_last,
                 bus.resp1_err, bus.resp0_err, (g ? bus.resp1_data : bus.resp0_data)}
                !== {g, ng, last & g, last & ng, exp_err & g, exp_err & ng, d}) begin
                miscompares++;
                $display("FAIL beat%0d: v1=%b v0=%b l1=%b l0=%b e1=%b e0=%b data=%h, required v%0d last=%b err=%b data=%h",
                         i, bus.resp1_valid, bus.resp0_valid, bus.resp1_last, bus.resp0_last,
                         bus.resp1_err, bus.resp0_err, (g ? bus.resp1_data : bus.resp0_data),
                         g, last, exp_err, d);
            end
        end
        vectors++;
        if ({bus.m_axi_rready, bus.m_axi_arvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL post_last: rready=%b arvalid=%b, required 0 0",
                     bus.m_axi_rready, bus.m_axi_arvalid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        step();
        vectors++;
        if (zero_outputs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: outputs=%h, required all zero", zero_outputs());
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 1'b1, 64'h0000_0000_1000_0014);
        run_burst(8, 2, 0, 0, 0, 0, 1'b1);
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(0, 1'b1, rand_addr());
        set_req(1, 1'b1, rand_addr());
        run_burst(8, 0, 0, 0, 0, 0, 1'b0);
        run_burst(8, 1, 0, 0, 0, 0, 1'b0);
        set_req(0, 1'b1, rand_addr());
        set_req(1, 1'b1, rand_addr());
        run_burst(8, 0, 0, 0, 0, 0, 1'b0);
        run_burst(8, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        set_req(1, 1'b1, rand_addr());
        run_burst(8, 5, 1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_errors();
        set_req(0, 1'b1, rand_addr());
        run_burst(8, 1, 0, 3, 0, 0, 1'b0);
        set_req(1, 1'b1, rand_addr());
        run_burst(6, 0, 0, 0, 0, 0, 1'b0);
        set_req(0, 1'b1, rand_addr());
        run_burst(8, 0, 0, 0, 5, 0, 1'b0);
        set_req(0, 1'b1, rand_addr());
        run_burst(10, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, rand_addr());
        run_burst(8, 0, 0, 0, 0, 5, 1'b0);
        set_req(1, 1'b1, rand_addr());
        run_burst(8, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        int nb;
        for (int it = 0; it < 40; it++) begin
            if (!req_v(0) && $urandom_range(0, 1) == 1) set_req(0, 1'b1, rand_addr());
            if (!req_v(1) && $urandom_range(0, 1) == 1) set_req(1, 1'b1, rand_addr());
            if (!req_v(0) && !req_v(1)) set_req(int'($urandom_range(0, 1)), 1'b1, rand_addr());
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 8;
            run_burst(nb, int'($urandom_range(0, 3)), 2, int'($urandom_range(0, 12)),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 0, 0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_stall();
        test_errors();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
